calc_ctrl: RTL

Sequencing controller for the 3-bit signed calculator ALU (add/sub, mul, rem). It accepts one operation request via valid/ready handshake, drives the ALU select and operand lines, and waits a fixed settle latency. It then captures the 5-bit signed result, flags remainder-by-zero, and holds the result until the consumer accepts it. It supports chaining, where the previous result (saturated to 3 bits) becomes the next A operand. Sits between the keypad/command front-end and the ALU at calculator top level.

---
 rtl/calc_pkg.sv | 24 ++
 rtl/calc_sat3.sv | 22 ++
 rtl/calc_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared types and constants for the calculator sequencing controller.
package calc_pkg;

  typedef enum logic [1:0] {
    CMD_ADD = 2'b00,
    CMD_SUB = 2'b01,
    CMD_MUL = 2'b10,
    CMD_REM = 2'b11
  } cmd_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [1:0] ALU_OP_ADDSUB = 2'b00;
  localparam logic [1:0] ALU_OP_MUL    = 2'b01;
  localparam logic [1:0] ALU_OP_REM    = 2'b10;

  localparam int SAT3_MAX = 3;
  localparam int SAT3_MIN = -4;

endpackage

// File: rtl/calc_sat3.sv
// Combinational 5-bit to 3-bit signed saturator; sat_flag_o marks a clamped value.
module calc_sat3
  import calc_pkg::*;
(
  input  logic signed [4:0] val_i,
  output logic signed [2:0] sat_o,
  output logic              sat_flag_o
);

  always_comb begin
    sat_o      = val_i[2:0];
    sat_flag_o = 1'b0;
    if (int'(val_i) > SAT3_MAX) begin
      sat_o      = 3'(SAT3_MAX);
      sat_flag_o = 1'b1;
    end else if (int'(val_i) < SAT3_MIN) begin
      sat_o      = 3'(SAT3_MIN);
      sat_flag_o = 1'b1;
    end
  end

endmodule

// File: rtl/calc_ctrl.sv
// Calculator ALU sequencer: accept, hold ALU inputs, capture, hand result off.
// Optional statistics counters are built when CALC_CTRL_STATS_EN is defined.
module calc_ctrl
  import calc_pkg::*;
#(
  parameter int ALU_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_a,
  input  logic [2:0] in_b,
  input  logic [1:0] in_cmd,
  input  logic       in_chain,
  input  logic       clear,
  output logic [2:0] alu_a,
  output logic [2:0] alu_b,
  output logic [1:0] alu_op,
  output logic       alu_sub_en,
  input  logic [4:0] alu_r,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [4:0] out_result,
  output logic       out_err,
  output logic       out_sat,
  output logic [7:0] stat_ops,
  output logic [7:0] stat_errs,
  output logic [1:0] dbg_state_o,
  output logic       dbg_acc_valid_o
);

  // Both ports use valid/ready: a transfer happens on a rising edge where
  // valid && ready; valid holds and payload stays stable until that edge.

  state_e             state_q, state_d;
  logic [2:0]         cnt_q, cnt_d;
  logic signed [4:0]  acc_q, acc_d;
  logic               acc_valid_q, acc_valid_d;
  logic [2:0]         alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [1:0]         alu_op_q, alu_op_d;
  logic               alu_sub_en_q, alu_sub_en_d;
  logic [4:0]         out_result_q, out_result_d;
  logic               out_err_q, out_err_d;
  logic               out_sat_q, out_sat_d;
  logic               use_chain;
  logic               rem_zero;
  logic signed [2:0]  acc_sat;
  logic               acc_sat_flag;

  calc_sat3 u_sat3 (
    .val_i      (acc_q),
    .sat_o      (acc_sat),
    .sat_flag_o (acc_sat_flag)
  );

  assign rem_zero = (alu_op_q == ALU_OP_REM) && (alu_b_q == 3'b000);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    acc_valid_d  = acc_valid_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_sub_en_d = alu_sub_en_q;
    out_result_d = out_result_q;
    out_err_d    = out_err_q;
    out_sat_d    = out_sat_q;
    use_chain    = 1'b0;
    case (state_q)
      IDLE: begin
        // clear beats chaining even when it arrives with the request
        if (clear) acc_valid_d = 1'b0;
        use_chain = in_chain && acc_valid_q && !clear;
        if (in_valid) begin
          alu_a_d      = use_chain ? acc_sat : in_a;
          alu_b_d      = in_b;
          out_sat_d    = use_chain && acc_sat_flag;
          alu_sub_en_d = 1'b0;
          case (cmd_e'(in_cmd))
            CMD_ADD: alu_op_d = ALU_OP_ADDSUB;
            CMD_SUB: begin
              alu_op_d     = ALU_OP_ADDSUB;
              alu_sub_en_d = 1'b1;
            end
            CMD_MUL: alu_op_d = ALU_OP_MUL;
            default: alu_op_d = ALU_OP_REM;
          endcase
          cnt_d   = 3'(ALU_LAT);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 3'd0) begin
          if (rem_zero) begin
            out_result_d = 5'd0;
            out_err_d    = 1'b1;
            acc_valid_d  = 1'b0;
          end else begin
            out_result_d = alu_r;
            out_err_d    = 1'b0;
            acc_d        = alu_r;
            acc_valid_d  = 1'b1;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= 3'd0;
      acc_q        <= 5'sd0;
      acc_valid_q  <= 1'b0;
      alu_a_q      <= 3'd0;
      alu_b_q      <= 3'd0;
      alu_op_q     <= 2'd0;
      alu_sub_en_q <= 1'b0;
      out_result_q <= 5'd0;
      out_err_q    <= 1'b0;
      out_sat_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      acc_valid_q  <= acc_valid_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_sub_en_q <= alu_sub_en_d;
      out_result_q <= out_result_d;
      out_err_q    <= out_err_d;
      out_sat_q    <= out_sat_d;
    end
  end

  assign in_ready        = (state_q == IDLE);
  assign out_valid       = (state_q == DONE);
  assign alu_a           = alu_a_q;
  assign alu_b           = alu_b_q;
  assign alu_op          = alu_op_q;
  assign alu_sub_en      = alu_sub_en_q;
  assign out_result      = out_result_q;
  assign out_err         = out_err_q;
  assign out_sat         = out_sat_q;
  assign dbg_state_o     = state_q;
  assign dbg_acc_valid_o = acc_valid_q;

`ifdef CALC_CTRL_STATS_EN
  logic [7:0] stat_ops_q, stat_errs_q;
  logic       accept, err_capture;

  assign accept      = (state_q == IDLE) && in_valid;
  assign err_capture = (state_q == EXEC) && (cnt_q == 3'd0) && rem_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q  <= 8'd0;
      stat_errs_q <= 8'd0;
    end else begin
      if (accept && stat_ops_q != 8'hff) stat_ops_q <= stat_ops_q + 8'd1;
      if (err_capture && stat_errs_q != 8'hff) stat_errs_q <= stat_errs_q + 8'd1;
    end
  end

  assign stat_ops  = stat_ops_q;
  assign stat_errs = stat_errs_q;
`else
  assign stat_ops  = 8'd0;
  assign stat_errs = 8'd0;
`endif

endmodule
